// File: rtl/match_readout_sequencer.sv
// match_readout_sequencer
//   Control and readout end of the single-grid X-stabilizer decoder.
//   On a go pulse it waits out a settle interval and pulses start_offer.
//   It then lets the grid run for the offer interval and pulses stop_offer.
//   Next it snapshots every node's measurement bit and match value.
//   Finally it scans the snapshot in row-major order and emits one (y, x, match)
//   record on a valid/ready stream for each node whose measurement bit is set.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   go           in   one-cycle request to run a round; honoured only when idle
//   measurement  in   NODES measurement bits; bit i = node (i / X, i % X)
//   match_value  in   NODES packed match values; slice i at [i*MVW +: MVW]
//   start_offer  out  one-cycle pulse to the grid
//   stop_offer   out  one-cycle pulse to the grid
//   rec_valid    out  record valid
//   rec_ready    in   downstream accepts the record when rec_valid && rec_ready
//   rec_y        out  row of the reporting node
//   rec_x        out  column of the reporting node
//   rec_match    out  snapshot match value of the reporting node
//   busy         out  high whenever the sequencer is not idle
//   done         out  one-cycle pulse at the end of a round
//   rec_count    out  records emitted this round; holds until the next go
module match_readout_sequencer #(
    parameter int GRID_WIDTH_X      = 3,
    parameter int GRID_WIDTH_Y      = 2,
    parameter int CORDINATE_WIDTH   = 2,
    parameter int MATCH_VALUE_WIDTH = 4,
    parameter int SETTLE_CYCLES     = 100,
    parameter int OFFER_CYCLES      = 2500
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   go,
    input  logic [GRID_WIDTH_X*GRID_WIDTH_Y-1:0]                   measurement,
    input  logic [GRID_WIDTH_X*GRID_WIDTH_Y*MATCH_VALUE_WIDTH-1:0] match_value,
    output logic                                                   start_offer,
    output logic                                                   stop_offer,
    output logic                                                   rec_valid,
    input  logic                                                   rec_ready,
    output logic [CORDINATE_WIDTH-1:0]                             rec_y,
    output logic [CORDINATE_WIDTH-1:0]                             rec_x,
    output logic [MATCH_VALUE_WIDTH-1:0]                           rec_match,
    output logic                                                   busy,
    output logic                                                   done,
    output logic [$clog2(GRID_WIDTH_X*GRID_WIDTH_Y+1)-1:0]         rec_count
);

    localparam int NODES   = GRID_WIDTH_X * GRID_WIDTH_Y;
    localparam int IDX_W   = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > OFFER_CYCLES) ? SETTLE_CYCLES : OFFER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // SETTLE spans SETTLE_CYCLES+1 cycles, so start_offer lands SETTLE_CYCLES+1
    // edges after the edge that accepts go. OFFER spans exactly OFFER_CYCLES
    // cycles, so stop_offer follows start_offer by OFFER_CYCLES+1 edges.
    localparam logic [CNT_W-1:0]           SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]           OFFER_LAST  = CNT_W'(OFFER_CYCLES - 1);
    localparam logic [IDX_W-1:0]           IDX_LAST    = IDX_W'(NODES - 1);
    localparam logic [CORDINATE_WIDTH-1:0] COL_LAST    = CORDINATE_WIDTH'(GRID_WIDTH_X - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_OFFER,
        S_STOP,
        S_LATCH,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]                   cnt;
    logic [IDX_W-1:0]                   idx;
    logic [CORDINATE_WIDTH-1:0]         row;
    logic [CORDINATE_WIDTH-1:0]         col;
    logic [NODES-1:0]                   snap_meas;
    logic [NODES*MATCH_VALUE_WIDTH-1:0] snap_match;

    logic                               cur_bit;
    logic [MATCH_VALUE_WIDTH-1:0]       cur_match;
    logic [IDX_W-1:0]                   idx_inc;
    logic [CORDINATE_WIDTH-1:0]         row_inc;
    logic [CORDINATE_WIDTH-1:0]         col_inc;

    // Current scan node and the position of the node after it. Row and column
    // are stepped alongside the linear index, so no divider is needed.
    always_comb begin
        cur_bit   = snap_meas[idx];
        cur_match = snap_match[idx*MATCH_VALUE_WIDTH +: MATCH_VALUE_WIDTH];
        idx_inc   = idx + 1'b1;
        if (col == COL_LAST) begin
            col_inc = '0;
            row_inc = row + 1'b1;
        end else begin
            col_inc = col + 1'b1;
            row_inc = row;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (go) state_next = S_SETTLE;
            S_SETTLE: if (cnt == SETTLE_LAST) state_next = S_START;
            S_START:  state_next = S_OFFER;
            S_OFFER:  if (cnt == OFFER_LAST) state_next = S_STOP;
            S_STOP:   state_next = S_LATCH;
            S_LATCH:  state_next = S_SCAN;
            S_SCAN: begin
                if (cur_bit) begin
                    state_next = S_EMIT;
                end else if (idx == IDX_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_EMIT: begin
                if (rec_ready) begin
                    state_next = (idx == IDX_LAST) ? S_DONE : S_SCAN;
                end
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        start_offer = (state == S_START);
        stop_offer  = (state == S_STOP);
        done        = (state == S_DONE);
        busy        = (state != S_IDLE);
    end

    // Counters, snapshot and record registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            idx        <= '0;
            row        <= '0;
            col        <= '0;
            snap_meas  <= '0;
            snap_match <= '0;
            rec_valid  <= 1'b0;
            rec_y      <= '0;
            rec_x      <= '0;
            rec_match  <= '0;
            rec_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        cnt       <= '0;
                        rec_count <= '0;
                    end
                end
                S_SETTLE, S_OFFER: cnt <= cnt + 1'b1;
                S_START:           cnt <= '0;
                S_LATCH: begin
                    // Inputs are captured once here and not looked at again this round.
                    snap_meas  <= measurement;
                    snap_match <= match_value;
                    idx        <= '0;
                    row        <= '0;
                    col        <= '0;
                end
                S_SCAN: begin
                    if (cur_bit) begin
                        rec_y     <= row;
                        rec_x     <= col;
                        rec_match <= cur_match;
                        rec_valid <= 1'b1;
                    end else begin
                        idx <= idx_inc;
                        row <= row_inc;
                        col <= col_inc;
                    end
                end
                S_EMIT: begin
                    if (rec_ready) begin
                        rec_valid <= 1'b0;
                        rec_count <= rec_count + 1'b1;
                        idx       <= idx_inc;
                        row       <= row_inc;
                        col       <= col_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_match_readout_sequencer.sv
module tb_match_readout_sequencer;

    localparam int GX     = 3;
    localparam int GY     = 2;
    localparam int CW     = 2;
    localparam int MVW    = 4;
    localparam int SETTLE = 100;
    localparam int OFFER  = 2500;
    localparam int NODES  = GX * GY;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   go = 1'b0;
    logic                   rec_ready = 1'b0;
    logic [NODES-1:0]       measurement = '0;
    logic [NODES*MVW-1:0]   match_value = '0;
    logic                   start_offer;
    logic                   stop_offer;
    logic                   rec_valid;
    logic [CW-1:0]          rec_y;
    logic [CW-1:0]          rec_x;
    logic [MVW-1:0]         rec_match;
    logic                   busy;
    logic                   done;
    logic [2:0]             rec_count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [CW-1:0]  y;
        logic [CW-1:0]  x;
        logic [MVW-1:0] m;
    } rec_t;

    always #5 clk = ~clk;

    match_readout_sequencer #(
        .GRID_WIDTH_X(GX),
        .GRID_WIDTH_Y(GY),
        .CORDINATE_WIDTH(CW),
        .MATCH_VALUE_WIDTH(MVW),
        .SETTLE_CYCLES(SETTLE),
        .OFFER_CYCLES(OFFER)
    ) dut (
        .clk(clk),
        .reset(reset),
        .go(go),
        .measurement(measurement),
        .match_value(match_value),
        .start_offer(start_offer),
        .stop_offer(stop_offer),
        .rec_valid(rec_valid),
        .rec_ready(rec_ready),
        .rec_y(rec_y),
        .rec_x(rec_x),
        .rec_match(rec_match),
        .busy(busy),
        .done(done),
        .rec_count(rec_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {15'd0, start_offer, stop_offer, rec_valid, rec_y, rec_x, rec_match,
                    busy, done, rec_count}, 32'd0);
    endtask

    // One decode round. The expected record list comes straight from the
    // row-major rule: every set measurement bit i yields (i/X, i%X, match[i]).
    task automatic run_round(input logic [NODES-1:0] meas, input logic [NODES*MVW-1:0] mv,
                             input int first_stall, input bit rand_ready,
                             input bit go_in_offer, input bit abort_in_emit);
        rec_t exp_q[$];
        int   n;
        int   elapsed;
        int   valid_cycles;
        int   got;
        int   stall;
        int   idle_busy;
        bit   ready_now;
        exp_q = {};
        for (int i = 0; i < NODES; i++) begin
            if (meas[i]) exp_q.push_back({CW'(i / GX), CW'(i % GX), mv[i*MVW +: MVW]});
        end
        measurement = meas;
        match_value = mv;

        go = 1'b1;
        tick();
        go = 1'b0;
        check("busy_after_go", busy, 1);
        check("rec_count_cleared", rec_count, 0);

        n = 0;
        while (start_offer !== 1'b1 && n < SETTLE + 50) begin
            tick();
            n++;
        end
        check("start_latency", n, SETTLE + 1);
        tick();
        check("start_width", start_offer, 0);

        n = 1;
        while (stop_offer !== 1'b1 && n < OFFER + 50) begin
            go = (go_in_offer && n == 500);
            tick();
            n++;
        end
        go = 1'b0;
        check("stop_latency", n, OFFER + 1);
        tick();
        check("stop_width", stop_offer, 0);
        check("no_rec_in_latch", rec_valid, 0);
        tick();
        // Snapshot has been taken; later input changes must not matter.
        measurement = NODES'($urandom);
        match_value = (NODES*MVW)'($urandom);

        elapsed = 1;
        valid_cycles = 0;
        got = 0;
        stall = first_stall;
        while (done !== 1'b1 && elapsed < 200) begin
            ready_now = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rec_valid === 1'b1) begin
                valid_cycles++;
                if (got < exp_q.size()) begin
                    check("rec_y", rec_y, exp_q[got].y);
                    check("rec_x", rec_x, exp_q[got].x);
                    check("rec_match", rec_match, exp_q[got].m);
                end else begin
                    check("extra_record", rec_valid, 0);
                end
                if (abort_in_emit) begin
                    #2 reset = 1'b0;
                    #1;
                    check_all_zero("abort_now");
                    rec_ready = 1'b1;
                    tick();
                    tick();
                    check_all_zero("abort_hold");
                    rec_ready = 1'b0;
                    reset = 1'b1;
                    repeat (5) tick();
                    check_all_zero("after_abort");
                    return;
                end
                if (stall > 0) begin
                    ready_now = 1'b0;
                    stall--;
                end
                if (ready_now) got++;
            end
            rec_ready = ready_now;
            tick();
            elapsed++;
        end
        rec_ready = 1'b0;

        check("done_time", elapsed, 1 + NODES + valid_cycles);
        check("rec_total", got, exp_q.size());
        check("rec_count", rec_count, exp_q.size());
        check("busy_in_done", busy, 1);
        check("valid_in_done", rec_valid, 0);
        tick();
        check("done_width", done, 0);
        check("busy_idle", busy, 0);
        check("rec_count_hold", rec_count, exp_q.size());

        idle_busy = 0;
        repeat (10) begin
            tick();
            if (busy !== 1'b0) idle_busy++;
        end
        check("stays_idle", idle_busy, 0);
    endtask

    initial begin
        logic [NODES*MVW-1:0] mv;
        int                   active;

        reset = 1'b0;
        repeat (3) tick();
        check_all_zero("reset_hold");
        reset = 1'b1;
        active = 0;
        repeat (50) begin
            tick();
            if ({start_offer, stop_offer, rec_valid, busy, done} !== 5'b0) active++;
        end
        check("idle_50_quiet", active, 0);
        check_all_zero("idle_50_outputs");

        // Two adjacent records with ready held high.
        mv = (NODES*MVW)'($urandom);
        mv[3:0] = 4'b0001;
        mv[7:4] = 4'b0000;
        run_round(6'b000011, mv, 0, 1'b0, 1'b0, 1'b0);

        // Same with the first record stalled for 20 cycles.
        run_round(6'b000011, mv, 20, 1'b0, 1'b0, 1'b0);

        // No set bits.
        run_round(6'b000000, (NODES*MVW)'($urandom), 0, 1'b0, 1'b0, 1'b0);

        // Every node reports, random backpressure.
        run_round(6'b111111, (NODES*MVW)'($urandom), 2, 1'b1, 1'b0, 1'b0);

        // Random patterns, random backpressure.
        for (int r = 0; r < 3; r++) begin
            run_round(NODES'($urandom), (NODES*MVW)'($urandom), $urandom_range(0, 3),
                      1'b1, 1'b0, 1'b0);
        end

        // Extra go during OFFER must be ignored.
        run_round(6'b100100, (NODES*MVW)'($urandom), 0, 1'b0, 1'b1, 1'b0);

        // Reset while a record is pending, then a clean round.
        run_round(6'b010010, (NODES*MVW)'($urandom), 0, 1'b0, 1'b0, 1'b1);
        run_round(6'b101001, (NODES*MVW)'($urandom), 1, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
